// File: rtl/plreg_multilane_skid.sv
// Pipeline register for a multi-lane issue bundle with a 2-entry skid buffer.
// The main entry is presented downstream. The skid entry absorbs the one
// bundle accepted while downstream stalls, so in_ready comes from state only.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   flush           drop all held bundles
//   in_valid/in_data/in_ready     upstream handshake (lane 0 oldest)
//   out_valid/out_data/out_ready  downstream handshake
//   stall_cnt, stat_clr           saturating stall-cycle counter and its clear
//   err_noncontig                 sticky flag for a non-contiguous lane mask
module plreg_multilane_skid #(
  parameter int unsigned LANES = 2,
  parameter int unsigned WIDTH = 128,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic                   out_ready,
  output logic [CNT_W-1:0]       stall_cnt,
  input  logic                   stat_clr,
  output logic                   err_noncontig
);

  localparam int unsigned DW = LANES * WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [LANES-1:0] main_vld_q, main_vld_d;
  logic [LANES-1:0] skid_vld_q, skid_vld_d;
  logic [DW-1:0]    main_dat_q, main_dat_d;
  logic [DW-1:0]    skid_dat_q, skid_dat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             in_fire;
  logic             out_fire;
  logic             contig;

  // Handshake decode; in_ready depends on the state register only.
  assign in_ready      = (state_q != ST_FULL);
  assign out_valid     = (state_q != ST_EMPTY) ? main_vld_q : '0;
  assign out_data      = main_dat_q;
  assign stall_cnt     = cnt_q;
  assign err_noncontig = err_q;

  assign in_fire  = (|in_valid) & in_ready;
  assign out_fire = (|out_valid) & out_ready;

  // A mask of the form 0..01..1 has no overlap with itself plus one.
  assign contig = ((in_valid & (in_valid + LANES'(1))) == '0);

  // Next-state logic for the skid FSM, status flag and stall counter.
  always_comb begin
    state_d    = state_q;
    main_vld_d = main_vld_q;
    main_dat_d = main_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    cnt_d      = cnt_q;
    err_d      = err_q;

    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d    = ST_ONE;
          main_vld_d = in_valid;
          main_dat_d = in_data;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_vld_d = in_valid;
          main_dat_d = in_data;
        end else if (in_fire) begin
          state_d    = ST_FULL;
          skid_vld_d = in_valid;
          skid_dat_d = in_data;
        end else if (out_fire) begin
          state_d    = ST_EMPTY;
          main_vld_d = '0;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d    = ST_ONE;
          main_vld_d = skid_vld_q;
          main_dat_d = skid_dat_q;
          skid_vld_d = '0;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush drops everything held, including a bundle accepted this cycle.
    if (flush) begin
      state_d    = ST_EMPTY;
      main_vld_d = '0;
      skid_vld_d = '0;
    end

    if (in_fire && !contig) begin
      err_d = 1'b1;
    end

    if (stat_clr) begin
      cnt_d = '0;
    end else if ((state_q != ST_EMPTY) && !out_ready && !flush && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_vld_q <= '0;
      main_dat_q <= '0;
      skid_vld_q <= '0;
      skid_dat_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_vld_q <= main_vld_d;
      main_dat_q <= main_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_plreg_multilane_skid.sv
// Bench for plreg_multilane_skid: a FIFO-of-bundles model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_plreg_multilane_skid;

  localparam int unsigned L  = 2;
  localparam int unsigned W  = 16;
  localparam int unsigned C  = 4;
  localparam int unsigned DW = L * W;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [L-1:0]  in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [L-1:0]  out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [C-1:0]  stall_cnt;
  logic          stat_clr;
  logic          err_noncontig;

  plreg_multilane_skid #(.LANES(L), .WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .stall_cnt(stall_cnt), .stat_clr(stat_clr), .err_noncontig(err_noncontig)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a bounded FIFO of up to two bundles, head is what is presented.
  typedef struct packed {
    logic [L-1:0]  v;
    logic [DW-1:0] d;
  } bund_t;

  bund_t m_q[$];
  int    m_cnt = 0;
  bit    m_err = 1'b0;

  function automatic bit is_contig(input logic [L-1:0] v);
    for (int i = 1; i < int'(L); i++) begin
      if (v[i] && !v[i-1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit    rdy, ifire, ofire;
    bund_t b;
    if (rst) begin
      m_q.delete();
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      rdy   = (m_q.size() < 2);
      ifire = (|in_valid) && rdy;
      ofire = (m_q.size() > 0) && out_ready;
      if (stat_clr) m_cnt = 0;
      else if ((m_q.size() > 0) && !out_ready && !flush && (m_cnt < (1 << C) - 1)) m_cnt++;
      if (ifire && !is_contig(in_valid)) m_err = 1'b1;
      if (flush) begin
        m_q.delete();
      end else begin
        if (ofire) void'(m_q.pop_front());
        if (ifire) begin
          b.v = in_valid;
          b.d = in_data;
          m_q.push_back(b);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 64'(out_valid), (m_q.size() > 0) ? 64'(m_q[0].v) : 64'd0);
      if (m_q.size() > 0) chk("out_data", 64'(out_data), 64'(m_q[0].d));
      chk("in_ready", 64'(in_ready), (m_q.size() < 2) ? 64'd1 : 64'd0);
      chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      chk("err_noncontig", 64'(err_noncontig), 64'(m_err));
    end
  end

  task automatic drive(input logic [L-1:0] v, input logic [DW-1:0] d,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = '0; in_data = '0;
    out_ready = 1'b0; stat_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    rst = 1'b0;

    // Pass-through with out_ready high.
    drive(2'b11, 32'hA1A1_A0A0, 1'b1, 1'b0);
    chk("pt_A_valid", 64'(out_valid), 64'h3);
    chk("pt_A_data", 64'(out_data), 64'hA1A1_A0A0);
    drive(2'b01, 32'hB1B1_B0B0, 1'b1, 1'b0);
    chk("pt_B_valid", 64'(out_valid), 64'h1);
    chk("pt_B_data", 64'(out_data), 64'hB1B1_B0B0);
    drive(2'b11, 32'hC1C1_C0C0, 1'b1, 1'b0);
    chk("pt_C_data", 64'(out_data), 64'hC1C1_C0C0);
    chk("pt_in_ready", 64'(in_ready), 64'd1);
    drive(2'b00, 32'h0, 1'b1, 1'b0);
    chk("pt_drain", 64'(out_valid), 64'h0);
    chk("pt_stall", 64'(stall_cnt), 64'd0);

    // Backpressure: A presented, B in skid, three stall cycles.
    drive(2'b11, 32'h2A2A_2A2A, 1'b0, 1'b0);
    drive(2'b11, 32'h2B2B_2B2B, 1'b0, 1'b0);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    drive(2'b00, 32'h0, 1'b0, 1'b0);
    drive(2'b00, 32'h0, 1'b0, 1'b0);
    chk("bp_stall3", 64'(stall_cnt), 64'd3);
    chk("bp_head_A", 64'(out_data), 64'h2A2A_2A2A);
    drive(2'b00, 32'h0, 1'b1, 1'b0);
    chk("bp_then_B", 64'(out_data), 64'h2B2B_2B2B);
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    drive(2'b00, 32'h0, 1'b1, 1'b0);
    chk("bp_empty", 64'(out_valid), 64'h0);

    // Flush in FULL with a bundle offered and out_ready low.
    drive(2'b11, 32'hD1D1_D0D0, 1'b0, 1'b0);
    drive(2'b11, 32'hE1E1_E0E0, 1'b0, 1'b0);
    drive(2'b11, 32'hF1F1_F0F0, 1'b0, 1'b1);
    chk("fl_full_valid", 64'(out_valid), 64'h0);
    chk("fl_full_ready", 64'(in_ready), 64'd1);
    chk("fl_full_stall", 64'(stall_cnt), 64'd4);
    drive(2'b00, 32'h0, 1'b1, 1'b0);
    chk("fl_full_gone", 64'(out_valid), 64'h0);

    // Flush coincident with delivery of G; H in flight is dropped.
    drive(2'b11, 32'h6161_6060, 1'b1, 1'b0);
    chk("fl_G_presented", 64'(out_data), 64'h6161_6060);
    drive(2'b01, 32'h4848_4848, 1'b1, 1'b1);
    chk("fl_out_empty", 64'(out_valid), 64'h0);
    drive(2'b00, 32'h0, 1'b1, 1'b0);
    chk("fl_H_dropped", 64'(out_valid), 64'h0);

    // Non-contiguous lane mask is stored as given and flags a sticky error.
    drive(2'b10, 32'h1234_5678, 1'b1, 1'b0);
    chk("nc_valid", 64'(out_valid), 64'h2);
    chk("nc_data", 64'(out_data), 64'h1234_5678);
    chk("nc_err", 64'(err_noncontig), 64'd1);
    drive(2'b11, 32'h9ABC_DEF0, 1'b1, 1'b0);
    drive(2'b00, 32'h0, 1'b1, 1'b0);
    chk("nc_err_sticky", 64'(err_noncontig), 64'd1);

    // Counter saturation, clear, then reset from FULL.
    drive(2'b11, 32'h1111_2222, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(2'b00, 32'h0, 1'b0, 1'b0);
    chk("sat_15", 64'(stall_cnt), 64'd15);
    stat_clr = 1'b1;
    drive(2'b00, 32'h0, 1'b0, 1'b0);
    stat_clr = 1'b0;
    chk("stat_clr", 64'(stall_cnt), 64'd0);
    drive(2'b11, 32'h3333_4444, 1'b0, 1'b0);
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    rst = 1'b1;
    drive(2'b11, 32'h5555_6666, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rst2_valid", 64'(out_valid), 64'h0);
    chk("rst2_stall", 64'(stall_cnt), 64'd0);
    chk("rst2_err", 64'(err_noncontig), 64'd0);
    chk("rst2_ready", 64'(in_ready), 64'd1);
    chk("rst2_data", 64'(out_data), 64'd0);
    drive(2'b00, 32'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/plreg_multilane_skid.md
Name: plreg_multilane_skid

Overview:
- Parametrised successor to the fixed two-slot pipeline registers between decode/execute and execute/writeback.
- Carries one issue bundle of LANES lanes, each WIDTH bits, with a per-lane valid bit.
- Uses a ready/valid handshake with a 2-entry skid buffer, so upstream stall is registered rather than a combinational stop chain.
- Adds flush, lane-contiguity checking and a saturating stall counter; one instance per pipeline boundary.

Parameters:
LANES, 2, number of issue lanes per bundle (1..8)
WIDTH, 128, payload bits per lane (pc, npc, decode word, operands, etc.)
CNT_W, 16, width of stall-cycle counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  discard all held bundles (branch mispredict / exception)
in_valid  in  LANES  per-lane valid of incoming bundle; lane 0 is oldest
in_data  in  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
in_ready  out  1  stage can accept a bundle this cycle
out_valid  out  LANES  per-lane valid of presented bundle
out_data  out  LANES*WIDTH  presented bundle payload
out_ready  in  1  downstream accepts presented bundle
stall_cnt  out  CNT_W  cycles the stage held a bundle with out_ready low
stat_clr  in  1  clears stall_cnt
err_noncontig  out  1  sticky: accepted bundle had non-contiguous in_valid

Behaviour:
- Definitions: in_fire = |in_valid & in_ready; out_fire = |out_valid & out_ready. A bundle with all in_valid=0 is not a transfer.
- Storage: main entry (presented) and skid entry; each holds LANES valid bits plus payload.
- States:
  - EMPTY: main invalid.
  - ONE: main valid, skid empty.
  - FULL: both valid.
- in_ready = (state != FULL), decoded from state register only. No combinational path from out_ready to in_ready.
- out_valid = main valid bits when state != EMPTY, else 0. out_data = main payload.
- Transitions when flush=0:
  - EMPTY: in_fire -> ONE, main<=in.
  - ONE: in_fire & out_fire -> ONE, main<=in. in_fire & !out_fire -> FULL, skid<=in. !in_fire & out_fire -> EMPTY. Otherwise hold.
  - FULL: out_fire -> ONE, main<=skid. Otherwise hold. No input is accepted in FULL.
- Latency: 1 cycle from in_fire to out_valid when EMPTY or when ONE with out_fire. Bundle order is strictly FIFO.
- Flush:
  - Next state is EMPTY; all stored valid bits are cleared. Payload registers may hold stale data.
  - Flush wins over a simultaneous in_fire: that bundle is dropped, but upstream treats it as consumed because in_ready was 1.
  - A simultaneous out_fire still counts downstream; the bundle presented that cycle is valid.
- Lane payloads are stored unmodified; invalid lanes' data is don't-care but still registered.
- Contiguity: in_valid accepted on in_fire must be of the form 0..01..1 (lane 0 valid whenever any lane is valid). Otherwise err_noncontig<=1, sticky until rst, and the bundle is still stored as given.
- Stall counter:
  - Increments when state != EMPTY & !out_ready & !flush.
  - Saturates at 2^CNT_W-1.
  - stat_clr sets it to 0 and wins over increment.
- Reset (sync, active-high, takes priority over flush/stat_clr):
  - state EMPTY, all valid bits 0, payload 0.
  - out_valid=0, out_data=0, stall_cnt=0, err_noncontig=0.
  - in_ready reads 1 from the first cycle after the reset edge.
  - Inputs during rst are ignored.

Test Plan:
- Pass-through, LANES=2, out_ready=1: bundles A{11},B{01},C{11} on consecutive cycles -> each appears 1 cycle later with identical out_valid/out_data; in_ready stays 1; stall_cnt=0.
- Backpressure: out_ready=0 for 3 cycles while A,B offered -> A presented, B in skid, in_ready=0 from cycle 2; stall_cnt=3. Release -> A, then B, in order; in_ready returns to 1 the cycle after A leaves.
- Flush in FULL with simultaneous in_valid and out_ready=0 -> next cycle out_valid=00, in_ready=1; neither old entry ever appears; stall_cnt does not increment on the flush cycle.
- Flush coincident with out_fire of A -> A counted delivered; next cycle EMPTY; a bundle in flight on in_* that cycle is dropped.
- Non-contiguous in_valid=10 -> stored and presented as 10; err_noncontig=1 and stays 1 through later valid traffic until rst.
- Saturation with CNT_W=4: hold out_ready=0 for 20 cycles -> stall_cnt=15. stat_clr pulse -> 0 next cycle. Reset mid-FULL -> out_valid=0, stall_cnt=0, err_noncontig=0.
